synch_ram_dp: RTL and testbench

Parametrised dual-port synchronous RAM: one read/write port (A) and one read-only port (B), both with registered addresses and single-cycle read latency. It adds a built-in clear engine that fills the whole array with a constant after reset or on request. It serves as the common storage primitive for PPU/CPU-side tables (palette, OAM, nametable scratch), where one agent writes while another reads concurrently.

---
 rtl/synch_ram_pkg.sv | 19 +
 rtl/synch_ram_clr_ctrl.sv | 60 ++++++
 rtl/synch_ram_dp.sv | 100 ++++++++++
 tb/tb_synch_ram_dp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/synch_ram_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | synch_ram_pkg                                                    |
// | Shared types and helpers for the synch_ram_dp storage primitive. |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package synch_ram_pkg;

    typedef enum logic [0:0] {
        CLR_IDLE = 1'b0,
        CLR_BUSY = 1'b1
    } clr_state_t;

    function automatic int unsigned ram_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/synch_ram_clr_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | synch_ram_clr_ctrl                                               |
// | Clear engine: walks every address once, writing CLEAR_VALUE.     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module synch_ram_clr_ctrl
    import synch_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 6,
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic [DATA_WIDTH-1:0] clr_data
);

    clr_state_t            state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? CLR_BUSY : CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                CLR_IDLE: begin
                    if (clear_req) begin
                        state_q <= CLR_BUSY;
                        cnt_q   <= '0;
                    end
                end
                CLR_BUSY: begin
                    // Counter wraps to 0 on the final address, ready for the next run.
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= CLR_IDLE;
                    end
                end
                default: begin
                    state_q <= CLR_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy     = (state_q == CLR_BUSY);
    assign clr_we   = busy;
    assign clr_addr = cnt_q;
    assign clr_data = CLEAR_VALUE;

endmodule
`default_nettype wire

// File: rtl/synch_ram_dp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | synch_ram_dp                                                     |
// | Dual-port RAM (A: R/W, B: R), write-first, with clear engine.    |
// | Option macro: SYNCH_RAM_OUTREG_EN adds an output pipeline stage. |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module synch_ram_dp
    import synch_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 6,
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_dout
);

    localparam int DEPTH = ram_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_a_q;
    logic [ADDR_WIDTH-1:0] addr_b_q;

    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic [DATA_WIDTH-1:0] w_clr_data;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;

    synch_ram_clr_ctrl #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .CLEAR_VALUE    (CLEAR_VALUE),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr_ctrl (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (w_clr_we),
        .clr_addr  (w_clr_addr),
        .clr_data  (w_clr_data)
    );

    // Clear engine owns the write port; port A writes are discarded while busy.
    assign w_we    = w_clr_we | (a_we & ~busy);
    assign w_waddr = w_clr_we ? w_clr_addr : a_addr;
    assign w_wdata = w_clr_we ? w_clr_data : a_din;

    always_ff @(posedge clk) begin
        if (!reset && w_we) begin
            mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            addr_a_q <= a_addr;
            addr_b_q <= b_addr;
        end
    end

`ifdef SYNCH_RAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] dout_a_q;
    logic [DATA_WIDTH-1:0] dout_b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_a_q <= '0;
            dout_b_q <= '0;
        end else begin
            dout_a_q <= mem[addr_a_q];
            dout_b_q <= mem[addr_b_q];
        end
    end

    assign a_dout = dout_a_q;
    assign b_dout = dout_b_q;
`else
    // Reading after the edge's write makes both ports write-first.
    assign a_dout = mem[addr_a_q];
    assign b_dout = mem[addr_b_q];
`endif

endmodule
`default_nettype wire

// File: tb/tb_synch_ram_dp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_synch_ram_dp                                                  |
// | Directed self-checking bench for synch_ram_dp.                   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_synch_ram_dp;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam logic [DW-1:0] CV = 8'hA5;
`ifdef SYNCH_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_req;
    logic          busy;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic [DW-1:0] a_dout;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_dout;

    logic          clear_req0;
    logic          busy0;
    logic          a_we0;
    logic [AW-1:0] a_addr0;
    logic [DW-1:0] a_din0;
    logic [DW-1:0] a_dout0;
    logic [AW-1:0] b_addr0;
    logic [DW-1:0] b_dout0;

    int n_cmp = 0;
    int n_bad = 0;
    int n;

    always #5 clk = ~clk;

    synch_ram_dp #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .CLEAR_VALUE (CV), .CLEAR_ON_RESET (1'b1)
    ) u_dut (
        .clk (clk), .reset (reset), .clear_req (clear_req), .busy (busy),
        .a_we (a_we), .a_addr (a_addr), .a_din (a_din), .a_dout (a_dout),
        .b_addr (b_addr), .b_dout (b_dout)
    );

    synch_ram_dp #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .CLEAR_VALUE (CV), .CLEAR_ON_RESET (1'b0)
    ) u_dut0 (
        .clk (clk), .reset (reset), .clear_req (clear_req0), .busy (busy0),
        .a_we (a_we0), .a_addr (a_addr0), .a_din (a_din0), .a_dout (a_dout0),
        .b_addr (b_addr0), .b_dout (b_dout0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lat();
        for (int k = 0; k < LAT; k++) tick();
    endtask

    task automatic write_a(input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_we = 1'b1; a_addr = ad; a_din = d;
        tick();
        a_we = 1'b0;
    endtask

    task automatic read_b(input string tag, input logic [AW-1:0] ad, input logic [DW-1:0] exp);
        b_addr = ad;
        wait_lat();
        chk(tag, 32'(b_dout), 32'(exp));
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 64; i++) read_b(tag, AW'(i), CV);
    endtask

    // Counts edges until busy drops; first edge of the window already taken by caller.
    task automatic count_busy(inout int cnt);
        while (busy && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; clear_req = 1'b0;
        a_we = 1'b0; a_addr = '0; a_din = '0; b_addr = '0;
        clear_req0 = 1'b0; a_we0 = 1'b0; a_addr0 = '0; a_din0 = '0; b_addr0 = '0;
        tick(); tick();
        chk("reset_busy_cor1", 32'(busy), 32'd1);
        chk("reset_busy_cor0", 32'(busy0), 32'd0);

        // Power-up clear: 64 busy edges after release.
        reset = 1'b0;
        tick();
        n = 1;
        chk("busy_after_release", 32'(busy), 32'd1);
        count_busy(n);
        chk("clear_len_reset", 32'(n), 32'd64);
        read_all("init_clear");

        // CLEAR_ON_RESET=0 instance: idle at once, writes accepted immediately.
        chk("cor0_idle", 32'(busy0), 32'd0);
        a_we0 = 1'b1; a_addr0 = 6'd63; a_din0 = 8'h11; b_addr0 = 6'd63;
        tick();
        a_we0 = 1'b0;
        for (int k = 1; k < LAT; k++) tick();
        chk("cor0_rd63", 32'(b_dout0), 32'h11);
        a_addr0 = 6'd63;
        wait_lat();
        chk("cor0_a_rd63", 32'(a_dout0), 32'h11);

        // Same-cycle write on A and read on A/B of the same address.
        a_we = 1'b1; a_addr = 6'd5; a_din = 8'h3C; b_addr = 6'd5;
        tick();
        a_we = 1'b0;
        for (int k = 1; k < LAT; k++) tick();
        chk("wf_a5", 32'(a_dout), 32'h3C);
        chk("wf_b5", 32'(b_dout), 32'h3C);

        write_a(6'd7, 8'h5A);
        write_a(6'd8, 8'hC3);
        write_a(6'd40, 8'h99);
        read_b("rd7", 6'd7, 8'h5A);
        read_b("rd8", 6'd8, 8'hC3);
        a_addr = 6'd40;
        wait_lat();
        chk("a_rd40", 32'(a_dout), 32'h99);
        read_b("rd5_keep", 6'd5, 8'h3C);
        read_b("rd6_untouched", 6'd6, CV);

        // Requested clear with dropped writes, a mid-clear read and a duplicate request.
        clear_req = 1'b1;
        tick();
        n = 0;
        clear_req = 1'b0;
        chk("busy_on_req", 32'(busy), 32'd1);
        a_we = 1'b1; a_addr = 6'd10; a_din = 8'h77;
        tick(); n++;
        a_we = 1'b0;
        while (n < 10) begin tick(); n++; end
        a_we = 1'b1; a_addr = 6'd3; a_din = 8'h77;
        tick(); n++;
        a_we = 1'b0;
        b_addr = 6'd40;
        for (int k = 0; k < LAT; k++) begin tick(); n++; end
        chk("mid_clear_rd40", 32'(b_dout), 32'h99);
        while (n < 20) begin tick(); n++; end
        clear_req = 1'b1;
        tick(); n++;
        clear_req = 1'b0;
        count_busy(n);
        chk("clear_len_req", 32'(n), 32'd64);
        read_b("drop_rd10", 6'd10, CV);
        read_b("drop_rd3", 6'd3, CV);
        read_b("cleared_rd40", 6'd40, CV);
        read_b("cleared_rd5", 6'd5, CV);

        // Reset in the middle of a clear restarts it from address 0.
        write_a(6'd50, 8'h12);
        read_b("pre_rd50", 6'd50, 8'h12);
        clear_req = 1'b1;
        tick();
        n = 0;
        clear_req = 1'b0;
        while (n < 30) begin tick(); n++; end
        reset = 1'b1;
        tick(); tick();
        chk("busy_in_reset", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        n = 1;
        count_busy(n);
        chk("clear_len_rst", 32'(n), 32'd64);
        read_all("rst_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
